// File: rtl/conv_enc_pkg.sv
// Shared types and constants for the convolutional encoder block scheduler.
package conv_enc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMeta,
        StLat,
        StWait,
        StStart,
        StEnc,
        StDrain
    } state_e;

    localparam logic SIZE_SMALL = 1'b0;
    localparam logic SIZE_LARGE = 1'b1;

    localparam int unsigned BYTES_SMALL = 132;
    localparam int unsigned BYTES_LARGE = 768;

    // Wide enough for any sensible block byte count.
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] SB_Q0 = 2'd0;
    localparam logic [1:0] SB_Q1 = 2'd1;
    localparam logic [1:0] SB_Q2 = 2'd2;

    function automatic logic [CNT_W-1:0] block_bytes(input logic size,
                                                     input int unsigned small_bytes,
                                                     input int unsigned large_bytes);
        return (size == SIZE_LARGE) ? CNT_W'(large_bytes) : CNT_W'(small_bytes);
    endfunction

endpackage

// File: rtl/conv_enc_sched_if.sv
// Scheduler bus: meta/data FIFO status, encoder handshake and sub-block drain signals.
interface conv_enc_sched_if #(
    parameter int unsigned FIFO_AW = 10
) ();
    logic               meta_empty;
    logic [7:0]         meta_q;
    logic               meta_rdreq;
    logic [FIFO_AW-1:0] data_usedw;
    logic               blk_ready;
    logic               enc_done;
    logic               out_ready;
    logic [2:0]         sb_rdreq;
    logic               sb_valid;
    logic [1:0]         sb_sel;
    logic               blk_size;
    logic               busy;
    logic               err_timeout;

    modport master (
        output meta_empty, meta_q, data_usedw, enc_done, out_ready,
        input  meta_rdreq, blk_ready, sb_rdreq, sb_valid, sb_sel, blk_size, busy, err_timeout
    );

    modport slave (
        input  meta_empty, meta_q, data_usedw, enc_done, out_ready,
        output meta_rdreq, blk_ready, sb_rdreq, sb_valid, sb_sel, blk_size, busy, err_timeout
    );
endinterface

// File: rtl/conv_sched_drain.sv
// Drains sub-blocks q0, q1, q2 of nbytes each under backpressure; registers the
// read strobe and sub-block index into sb_valid/sb_sel one cycle later.
module conv_sched_drain
    import conv_enc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] nbytes,
    input  logic             out_ready,
    output logic [2:0]       sb_rdreq,
    output logic             sb_valid,
    output logic [1:0]       sb_sel,
    output logic             done
);
    logic             active_q, active_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd, last_byte;

    always_comb begin
        rd        = active_q & out_ready;
        last_byte = (cnt_q == nbytes - CNT_W'(1));
        sb_rdreq  = 3'b000;
        if (rd) sb_rdreq[sel_q] = 1'b1;
        done      = rd & last_byte & (sel_q == SB_Q2);
        active_d  = active_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        if (start) begin
            active_d = 1'b1;
            sel_d    = SB_Q0;
            cnt_d    = '0;
        end else if (rd) begin
            if (last_byte) begin
                cnt_d = '0;
                sel_d = sel_q + 2'd1;
                if (sel_q == SB_Q2) begin
                    active_d = 1'b0;
                    sel_d    = SB_Q0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= 1'b0;
            sel_q    <= SB_Q0;
            cnt_q    <= '0;
            sb_valid <= 1'b0;
            sb_sel   <= SB_Q0;
        end else begin
            active_q <= active_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            sb_valid <= |sb_rdreq;
            sb_sel   <= sel_q;
        end
    end
endmodule

// File: rtl/conv_enc_sched.sv
// Block scheduler for the convolutional encoder: meta pop, data wait, encoder start, drain.
// Optional encode watchdog enabled by defining CONV_SCHED_TIMEOUT_EN.
module conv_enc_sched
    import conv_enc_pkg::*;
#(
    parameter int unsigned FIFO_AW     = 10,
    parameter int unsigned SMALL_BYTES = BYTES_SMALL,
    parameter int unsigned LARGE_BYTES = BYTES_LARGE,
    parameter int unsigned TIMEOUT_CYC = 8192
) (
    input logic              clk,
    input logic              reset,
    conv_enc_sched_if.slave  bus
);
    state_e           state_q, state_d;
    logic             blk_size_q, blk_size_d;
    logic [CNT_W-1:0] nbytes;
    logic             drain_start, drain_done;

    assign nbytes = block_bytes(blk_size_q, SMALL_BYTES, LARGE_BYTES);

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TO_W-1:0] enc_cnt_q;
    logic            err_q;
    logic            enc_to;

    // enc_cnt_q holds the number of ENC cycles already completed.
    assign enc_to          = (state_q == StEnc) && (enc_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    assign bus.err_timeout = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            enc_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            enc_cnt_q <= (state_q == StEnc) ? enc_cnt_q + 1'b1 : '0;
            if (enc_to && !bus.enc_done) err_q <= 1'b1;
        end
    end
`else
    assign bus.err_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        blk_size_d  = blk_size_q;
        drain_start = 1'b0;
        unique case (state_q)
            StIdle:  if (!bus.meta_empty) state_d = StMeta;
            StMeta:  state_d = StLat;
            StLat: begin
                blk_size_d = bus.meta_q[0];
                state_d    = StWait;
            end
            StWait:  if (32'(bus.data_usedw) >= 32'(nbytes)) state_d = StStart;
            StStart: state_d = StEnc;
            StEnc: begin
                if (bus.enc_done) begin
                    state_d     = StDrain;
                    drain_start = 1'b1;
                end
`ifdef CONV_SCHED_TIMEOUT_EN
                else if (enc_to) begin
                    state_d = StIdle;
                end
`endif
            end
            StDrain: if (drain_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            blk_size_q <= SIZE_SMALL;
        end else begin
            state_q    <= state_d;
            blk_size_q <= blk_size_d;
        end
    end

    assign bus.meta_rdreq = (state_q == StMeta);
    assign bus.blk_ready  = (state_q == StStart);
    assign bus.busy       = (state_q != StIdle);
    assign bus.blk_size   = blk_size_q;

    conv_sched_drain u_drain (
        .clk       (clk),
        .reset     (reset),
        .start     (drain_start),
        .nbytes    (nbytes),
        .out_ready (bus.out_ready),
        .sb_rdreq  (bus.sb_rdreq),
        .sb_valid  (bus.sb_valid),
        .sb_sel    (bus.sb_sel),
        .done      (drain_done)
    );
endmodule

// File: tb/tb_conv_enc_sched.sv
// Self-checking bench for conv_enc_sched: randomized blocks against a cycle-accurate
// behavioural model of the scheduler's externally visible sequence.
module tb_conv_enc_sched;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    conv_enc_sched_if #(.FIFO_AW(10)) bus ();

    conv_enc_sched #(
        .FIFO_AW     (10),
        .SMALL_BYTES (132),
        .LARGE_BYTES (768),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Enter the next cycle; inputs driven here are seen by the following edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic common(input bit exp_meta, input bit exp_blk, input bit exp_busy);
        check("meta_rdreq", bus.meta_rdreq, exp_meta);
        check("blk_ready", bus.blk_ready, exp_blk);
        check("busy", bus.busy, exp_busy);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_meta_rdreq"}, bus.meta_rdreq, 0);
        check({tag, "_blk_ready"}, bus.blk_ready, 0);
        check({tag, "_sb_rdreq"}, bus.sb_rdreq, 0);
        check({tag, "_sb_valid"}, bus.sb_valid, 0);
        check({tag, "_sb_sel"}, bus.sb_sel, 0);
        check({tag, "_blk_size"}, bus.blk_size, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_err_timeout"}, bus.err_timeout, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        #1;
        check_zero("reset");
    endtask

    task automatic idle_cycles(input int n);
        bus.meta_empty = 1'b1;
        for (int i = 0; i < n; i++) begin
            next_cycle();
            bus.out_ready = 1'($urandom);
            #1;
            common(0, 0, 0);
            check("idle_sb_rdreq", bus.sb_rdreq, 0);
        end
    endtask

    // One block from an IDLE cycle. enc_lat < 0 withholds enc_done; abort_at >= 0
    // pulses reset when sub-block 1 has had abort_at bytes read.
    task automatic run_block(input bit size, input int wait_cyc, input int enc_lat,
                             input int or_mode, input bit keep_meta, input int abort_at);
        int nb;
        logic [7:0] mbyte;
        int exp_sel, left, cyc;
        bit prev_valid;
        int prev_sel;
        int reads [3];
        nb = size ? 768 : 132;
        mbyte = 8'($urandom);
        mbyte[0] = size;

        bus.meta_empty = 1'b0;
        next_cycle();                                   // META
        if (!keep_meta) bus.meta_empty = 1'b1;
        #1;
        common(1, 0, 1);
        next_cycle();                                   // LAT
        bus.meta_q = mbyte;
        #1;
        common(0, 0, 1);
        next_cycle();                                   // first WAIT
        bus.meta_q = 8'($urandom);
        if (wait_cyc > 0) bus.data_usedw = 10'($urandom_range(0, nb - 1));
        else bus.data_usedw = 10'(nb);
        #1;
        common(0, 0, 1);
        check("blk_size", bus.blk_size, size);
        for (int i = 0; i < wait_cyc; i++) begin
            next_cycle();
            bus.enc_done = ($urandom_range(0, 3) == 0);  // ignored outside ENC
            if (i == wait_cyc - 1) bus.data_usedw = 10'($urandom_range(nb, 1023));
            else if (i == wait_cyc - 2) bus.data_usedw = 10'(nb - 1);
            else bus.data_usedw = 10'($urandom_range(0, nb - 1));
            #1;
            common(0, 0, 1);
        end
        next_cycle();                                   // START
        bus.enc_done = 1'b0;
        #1;
        common(0, 1, 1);

        if (enc_lat < 0) begin
`ifdef CONV_SCHED_TIMEOUT_EN
            for (int i = 1; i <= 64; i++) begin
                next_cycle();
                #1;
                common(0, 0, 1);
                check("to_err_early", bus.err_timeout, 0);
            end
            next_cycle();
            #1;
            common(0, 0, 0);
            check("to_err_set", bus.err_timeout, 1);
            idle_cycles(3);
            check("to_err_sticky", bus.err_timeout, 1);
`else
            for (int i = 1; i <= 150; i++) begin
                next_cycle();
                bus.out_ready = 1'($urandom);
                #1;
                common(0, 0, 1);
                check("to_sb_rdreq", bus.sb_rdreq, 0);
                check("to_err", bus.err_timeout, 0);
            end
`endif
            return;
        end

        for (int i = 0; i <= enc_lat; i++) begin
            next_cycle();                               // ENC
            bus.enc_done = (i == enc_lat);
            bus.out_ready = 1'($urandom);
            #1;
            common(0, 0, 1);
            check("enc_sb_rdreq", bus.sb_rdreq, 0);
        end

        exp_sel = 0;
        left = nb;
        prev_valid = 0;
        prev_sel = 0;
        cyc = 0;
        reads = '{0, 0, 0};
        while (exp_sel < 3) begin
            next_cycle();                               // DRAIN
            bus.enc_done = 1'b0;
            if (abort_at >= 0 && exp_sel == 1 && (nb - left) == abort_at) begin
                reset = 1'b0;
                bus.out_ready = 1'b1;
                next_cycle();
                reset = 1'b1;
                #1;
                check_zero("abort");
                return;
            end
            case (or_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = cyc[0] ? 1'b0 : 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
            cyc++;
            #1;
            common(0, 0, 1);
            check("sb_rdreq", bus.sb_rdreq, bus.out_ready ? (32'd1 << exp_sel) : 32'd0);
            check("sb_valid", bus.sb_valid, prev_valid);
            if (prev_valid) check("sb_sel", bus.sb_sel, prev_sel);
            prev_valid = bus.out_ready;
            prev_sel = exp_sel;
            if (bus.out_ready) begin
                reads[exp_sel]++;
                left--;
                if (left == 0) begin
                    exp_sel++;
                    left = nb;
                end
            end
        end
        next_cycle();                                   // back in IDLE
        bus.out_ready = 1'($urandom);
        #1;
        common(0, 0, 0);
        check("tail_sb_rdreq", bus.sb_rdreq, 0);
        check("tail_sb_valid", bus.sb_valid, 1);
        check("tail_sb_sel", bus.sb_sel, 2);
        for (int s = 0; s < 3; s++) check("sb_bytes", reads[s], nb);
    endtask

    initial begin
        bus.meta_empty = 1'b1;
        bus.meta_q     = 8'h00;
        bus.data_usedw = '0;
        bus.enc_done   = 1'b0;
        bus.out_ready  = 1'b0;
        reset = 1'b0;
        next_cycle();
        do_reset();
        idle_cycles(3);

        run_block(0, 0, 5, 0, 0, -1);                   // small, data ready
        idle_cycles(2);
        run_block(1, 3, 7, 0, 0, -1);                   // large, usedw ramp
        idle_cycles(2);
        run_block(0, 2, 3, 1, 0, -1);                   // toggling out_ready
        run_block(1, 1, 2, 1, 0, -1);
        idle_cycles(1);
        run_block(0, 1, 4, 2, 1, -1);                   // two metas back-to-back
        run_block(1, 0, 2, 0, 0, -1);
        idle_cycles(2);
        run_block(1, 0, 3, 0, 0, 50);                   // reset mid-drain
        run_block(0, 0, 2, 0, 0, -1);
        for (int b = 0; b < 4; b++) begin
            run_block(($urandom_range(0, 3) == 0), $urandom_range(0, 4), $urandom_range(0, 20),
                      $urandom_range(0, 2), $urandom_range(0, 1), -1);
        end
        idle_cycles(2);
        run_block(0, 0, -1, 0, 0, -1);                  // enc_done withheld
        do_reset();
        run_block(0, 1, 1, 2, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
